// File: rtl/screen_writer.sv
// screen_writer: write-side engine for the character screen memory.
// Accepts put-char / set-cursor / newline / clear commands over valid/ready,
// tracks a text cursor and drives the memory write port. Clear sweeps every
// cell with code 0, one cell per cycle, while holding off new commands.
module screen_writer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int CODE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CODE_W-1:0] cmd_code,
  input  logic [5:0]        cmd_col,
  input  logic [4:0]        cmd_row,
  output logic              wr_en,
  output logic [10:0]       wr_addr,
  output logic [CODE_W-1:0] wr_data,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [1:0]  OP_PUT = 2'b00;
  localparam logic [1:0]  OP_SET = 2'b01;
  localparam logic [1:0]  OP_CLR = 2'b10;
  localparam logic [1:0]  OP_NL  = 2'b11;

  localparam logic [5:0]  LP_COLS = 6'(COLS);
  localparam logic [4:0]  LP_ROWS = 5'(ROWS);
  localparam logic [5:0]  LP_CMAX = 6'(COLS - 1);
  localparam logic [4:0]  LP_RMAX = 5'(ROWS - 1);
  localparam logic [10:0] LP_COLS_A = 11'(COLS);
  localparam logic [10:0] LP_LAST   = 11'(COLS * ROWS - 1);

  state_t              r_state;
  logic                r_wr_en;
  logic [10:0]         r_wr_addr;
  logic [CODE_W-1:0]   r_wr_data;
  logic [5:0]          r_col;
  logic [4:0]          r_row;
  logic                r_busy;

  logic                w_ready;
  logic                w_accept;
  logic [10:0]         w_lin;
  logic                w_col_last;
  logic                w_row_last;
  logic [5:0]          w_col_inc;
  logic [4:0]          w_row_inc;
  logic                w_set_ok;
  logic                w_sweep_done;

  // Handshake, cursor arithmetic and linear address of the current cursor cell
  always_comb begin
    w_ready      = (r_state == IDLE);
    w_accept     = cmd_valid & w_ready;
    // Widen before multiplying so row*COLS (max 1199) is never truncated
    w_lin        = 11'(r_row) * LP_COLS_A + 11'(r_col);
    w_col_last   = (r_col == LP_CMAX);
    w_row_last   = (r_row == LP_RMAX);
    w_col_inc    = w_col_last ? 6'd0 : r_col + 6'd1;
    w_row_inc    = w_row_last ? 5'd0 : r_row + 5'd1;
    w_set_ok     = (cmd_col < LP_COLS) && (cmd_row < LP_ROWS);
    w_sweep_done = (r_wr_addr == LP_LAST);
  end

  // Command FSM: write port, cursor and clear sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Strobe lasts one cycle unless another put char lands right behind it
          r_wr_en <= 1'b0;
          if (w_accept) begin
            case (cmd_op)
              OP_PUT: begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_lin;
                r_wr_data <= cmd_code;
                r_col     <= w_col_inc;
                if (w_col_last) r_row <= w_row_inc;
              end
              OP_SET: begin
                // Out-of-range targets are swallowed without moving the cursor
                if (w_set_ok) begin
                  r_col <= cmd_col;
                  r_row <= cmd_row;
                end
              end
              OP_NL: begin
                r_col <= '0;
                r_row <= w_row_inc;
              end
              OP_CLR: begin
                r_state   <= CLEAR;
                r_busy    <= 1'b1;
                r_wr_en   <= 1'b1;
                r_wr_addr <= '0;
                r_wr_data <= '0;
                r_col     <= '0;
                r_row     <= '0;
              end
              default: ;
            endcase
          end
        end
        CLEAR: begin
          // The address register doubles as the sweep counter
          if (w_sweep_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_wr_en <= 1'b0;
          end else begin
            r_wr_addr <= r_wr_addr + 11'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = w_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cursor_col = r_col;
  assign cursor_row = r_row;
  assign busy       = r_busy;

endmodule

// File: tb/tb_screen_writer.sv
// Testbench for screen_writer: directed commands, expected writes queued in a
// scoreboard and checked by an independent monitor on the falling edge.
module tb_screen_writer;

  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int CODE_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [CODE_W-1:0] cmd_code = '0;
  logic [5:0]        cmd_col = '0;
  logic [4:0]        cmd_row = '0;
  logic              wr_en;
  logic [10:0]       wr_addr;
  logic [CODE_W-1:0] wr_data;
  logic [5:0]        cursor_col;
  logic [4:0]        cursor_row;
  logic              busy;

  typedef struct packed {
    logic [10:0]       addr;
    logic [CODE_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  screen_writer #(.COLS(COLS), .ROWS(ROWS), .CODE_W(CODE_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_code(cmd_code), .cmd_col(cmd_col), .cmd_row(cmd_row),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: every observed write must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%0d required=no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          bad++;
          $display("FAIL write got addr=%0d data=%0d required addr=%0d data=%0d",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic push_wr(input int addr, input int data);
    wr_t e;
    e.addr = 11'(addr);
    e.data = CODE_W'(data);
    exp_q.push_back(e);
  endtask

  // Issue one command; returns #1 after the accepting edge
  task automatic send(input logic [1:0] op, input int code, input int col, input int row);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_code  = CODE_W'(code);
    cmd_col   = 6'(col);
    cmd_row   = 5'(row);
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic put(input int code, input int addr);
    push_wr(addr, code);
    send(2'b00, code, 0, 0);
  endtask

  task automatic cursor_is(input string name, input int col, input int row);
    check({name, "_col"}, int'(cursor_col), col);
    check({name, "_row"}, int'(cursor_row), row);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int low_cnt;
    // Reset state
    #2;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_busy", int'(busy), 0);
    cursor_is("rst", 0, 0);
    idle(2);
    reset = 1'b0;
    idle(1);
    check("rst_ready", int'(cmd_ready), 1);

    // Put char at origin
    put(2, 0);
    check("put0_wr_en", int'(wr_en), 1);
    check("put0_wr_addr", int'(wr_addr), 0);
    check("put0_wr_data", int'(wr_data), 2);
    cursor_is("put0", 1, 0);
    idle(1);
    check("put0_strobe_drop", int'(wr_en), 0);

    // End-of-row and end-of-screen wrap
    send(2'b01, 0, 39, 0);
    cursor_is("set39_0", 39, 0);
    put(1, 39);
    cursor_is("wrap_row", 0, 1);
    send(2'b01, 0, 39, 29);
    put(3, 1199);
    cursor_is("wrap_screen", 0, 0);
    idle(2);

    // Out-of-range set cursor is consumed, cursor unchanged
    send(2'b01, 0, 5, 5);
    send(2'b01, 0, 40, 5);
    check("bad_col_ready", int'(cmd_ready), 1);
    cursor_is("bad_col", 5, 5);
    send(2'b01, 0, 3, 30);
    cursor_is("bad_row", 5, 5);

    // Newline
    send(2'b01, 0, 3, 5);
    send(2'b11, 0, 0, 0);
    cursor_is("nl", 0, 6);
    send(2'b01, 0, 3, 29);
    send(2'b11, 0, 0, 0);
    cursor_is("nl_wrap", 0, 0);
    idle(2);

    // Full clear from (7,12)
    send(2'b01, 0, 7, 12);
    for (int i = 0; i < COLS * ROWS; i++) push_wr(i, 0);
    send(2'b10, 0, 0, 0);
    check("clr_busy", int'(busy), 1);
    check("clr_ready", int'(cmd_ready), 0);
    check("clr_wr_addr0", int'(wr_addr), 0);
    cursor_is("clr", 0, 0);
    low_cnt = 0;
    for (int i = 1; i < 1200; i++) begin
      @(posedge clk); #1;
      if (!cmd_ready && busy && wr_en) low_cnt++;
    end
    check("clr_held_cycles", low_cnt, 1199);
    @(posedge clk); #1;
    check("clr_done_ready", int'(cmd_ready), 1);
    check("clr_done_busy", int'(busy), 0);
    check("clr_done_wr_en", int'(wr_en), 0);
    check("clr_queue_drained", exp_q.size(), 0);

    // 40 back-to-back put chars, valid held every cycle
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    for (int i = 0; i < COLS; i++) begin
      cmd_code = CODE_W'(i % 4);
      push_wr(i, i % 4);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    cursor_is("b2b", 0, 1);
    idle(2);
    check("b2b_queue_drained", exp_q.size(), 0);

    // Reset during the 600th clear cycle
    send(2'b01, 0, 9, 9);
    for (int i = 0; i < 599; i++) push_wr(i, 0);
    send(2'b10, 0, 0, 0);
    repeat (599) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_wr_en", int'(wr_en), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_wr_addr", int'(wr_addr), 0);
    cursor_is("mid_rst", 0, 0);
    idle(2);
    reset = 1'b0;
    idle(1);
    check("mid_rst_ready", int'(cmd_ready), 1);
    idle(20);
    check("mid_rst_no_writes", exp_q.size(), 0);
    check("mid_rst_idle_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/screen_writer.md
# screen_writer

Write-side engine for the 40×30 character screen memory. It accepts character commands over a valid/ready handshake and keeps a text cursor. It produces the write port (enable, linear address, character code) of the dual-port screen memory whose read port feeds the VGA character renderer. It also implements a full-screen clear that sweeps all 1200 cells with code 0.

## Interface
Parameters:
- COLS, 40, characters per row
- ROWS, 30, rows per screen
- CODE_W, 2, character code width (matches screen memory cell width)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command this cycle
- cmd_op  input  2  00 put char, 01 set cursor, 10 clear screen, 11 newline
- cmd_code  input  CODE_W  character code for put char
- cmd_col  input  6  target column for set cursor
- cmd_row  input  5  target row for set cursor
- wr_en  output  1  screen memory write strobe
- wr_addr  output  11  linear cell address, row*COLS+col
- wr_data  output  CODE_W  code to write
- cursor_col  output  6  current cursor column
- cursor_row  output  5  current cursor row
- busy  output  1  clear sweep in progress

## Operation
- States: IDLE, CLEAR. Reset → IDLE.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cursor_col=0, cursor_row=0, busy=0. cmd_ready=1 once reset deasserts.
- cmd_ready = (state==IDLE), combinational. busy = (state==CLEAR).
- A command is accepted on a rising edge with cmd_valid && cmd_ready. Inputs are don't-care otherwise.
- Put char (00):
  - wr_en=1 for one cycle; wr_addr = cursor_row*COLS+cursor_col (pre-advance cursor); wr_data=cmd_code.
  - Cursor advances: col+1. At col==COLS-1, col→0 and row+1. At row==ROWS-1 with col==COLS-1, cursor wraps to (0,0). No scrolling.
- Set cursor (01):
  - If cmd_col<COLS and cmd_row<ROWS, the cursor is loaded. Otherwise the command is consumed and the cursor is unchanged.
  - No write.
- Newline (11): col→0, row+1, and row ROWS-1 wraps to 0. No write.
- Clear (10):
  - → CLEAR and cursor→(0,0).
  - Emits wr_en=1, wr_data=0 with wr_addr 0,1,…,COLS*ROWS-1 on consecutive cycles.
  - After the last address, → IDLE.
- wr_addr width rule: product computed at ≥11 bits. Maximum is 1199, so no truncation occurs. A running linear address register is acceptable if it stays equal to row*COLS+col.
- wr_en=0 in every IDLE cycle with no accepted put char in the previous cycle. wr_addr and wr_data hold their last values when wr_en=0.

## Timing
- All outputs except cmd_ready are registered.
- Put char accepted at edge E:
  - wr_en/wr_addr/wr_data valid in the cycle after E (one-cycle latency).
  - Cursor outputs show the advanced position after E.
- Back-to-back put chars are sustained at one per cycle, because cmd_ready stays high during the write cycle.
- Clear accepted at edge E:
  - After E: busy=1, cmd_ready=0, wr_en=1, wr_addr=0.
  - wr_addr increments each edge through 1199, so wr_en is high for exactly 1200 cycles.
  - The edge after the cycle carrying 1199 gives wr_en=0, busy=0, cmd_ready=1.
  - The first new command can be accepted 1201 cycles after E.
- cmd_valid during CLEAR is not accepted. The upstream must hold it until cmd_ready is high.
- Reset asserted mid-clear or mid-write:
  - All outputs go immediately to their reset values.
  - The sweep is abandoned, and partially cleared memory contents are left as-is.

## Test plan
- Reset, then put char code 2 → wr_en=1 one cycle later with wr_addr=0, wr_data=2; cursor (1,0).
- Set cursor (39,0) then put char 1 → wr_addr=39, cursor (0,1). Set cursor (39,29) then put char 3 → wr_addr=1199, cursor (0,0).
- Set cursor (40,5) and (3,30) → both consumed with cmd_ready high and no write; cursor unchanged. Set cursor (3,5), then newline → cursor (0,6). Newline from row 29 → row 0.
- Clear with cursor at (7,12) → 1200 write cycles with addresses 0..1199 in order, all wr_data=0; cmd_ready low throughout; cursor (0,0); cmd_ready high at cycle E+1201.
- 40 consecutive put chars held valid every cycle → 40 consecutive wr_en cycles with addresses 0..39; cursor (0,1).
- Assert reset at the 600th clear cycle → wr_en=0, busy=0, cursor (0,0) immediately. After release, cmd_ready=1 and no further writes occur.
